// File: rtl/hazard_stall_unit_pkg.sv
//------------------------------------------------------------------------------
// Module   : hazard_stall_unit_pkg
// Brief    : Shared pipeline constants and types for the hazard stall unit.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package hazard_stall_unit_pkg;
    localparam int REG_W          = 5;
    localparam int NUM_REGS       = 32;
    localparam int MULDIV_LAT_DEF = 4;

    typedef logic [REG_W-1:0]    reg_idx_t;
    typedef logic [NUM_REGS-1:0] reg_mask_t;

    localparam reg_idx_t REG_ZERO = '0;
endpackage

`default_nettype wire

// File: rtl/hazard_stall_unit_if.sv
//------------------------------------------------------------------------------
// Module   : hazard_stall_unit_if
// Brief    : Decode-stage hazard bus between the pipeline and the stall unit.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface hazard_stall_unit_if
    import hazard_stall_unit_pkg::*;
#(
    parameter int CNT_W = 16
);
    logic             id_valid;
    reg_idx_t         id_reg_rs;
    reg_idx_t         id_reg_rt;
    logic             id_uses_rs;
    logic             id_uses_rt;
    reg_idx_t         id_reg_rd;
    logic             id_reg_write;
    logic             id_is_muldiv;
    logic             exe_mem_read;
    reg_idx_t         exe_reg_rd;
    logic             branch_taken;
    logic             stall_if;
    logic             stall_id;
    logic             bubble_ex;
    logic             flush_id;
    logic             muldiv_busy;
    logic             muldiv_wb;
    logic [CNT_W-1:0] stall_count;

    modport master (
        output id_valid, id_reg_rs, id_reg_rt, id_uses_rs, id_uses_rt,
               id_reg_rd, id_reg_write, id_is_muldiv, exe_mem_read,
               exe_reg_rd, branch_taken,
        input  stall_if, stall_id, bubble_ex, flush_id, muldiv_busy,
               muldiv_wb, stall_count
    );

    modport slave (
        input  id_valid, id_reg_rs, id_reg_rt, id_uses_rs, id_uses_rt,
               id_reg_rd, id_reg_write, id_is_muldiv, exe_mem_read,
               exe_reg_rd, branch_taken,
        output stall_if, stall_id, bubble_ex, flush_id, muldiv_busy,
               muldiv_wb, stall_count
    );
endinterface

`default_nettype wire

// File: rtl/hazard_stall_unit_mul_div_scoreboard.sv
//------------------------------------------------------------------------------
// Module   : mul_div_scoreboard
// Brief    : Pending-register scoreboard and countdown for the in-flight mul/div.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mul_div_scoreboard
    import hazard_stall_unit_pkg::*;
#(
    parameter int MULDIV_LAT = MULDIV_LAT_DEF
) (
    input  wire logic      clk,
    input  wire logic      arst_n,
    input  wire logic      issue_i,
    input  wire reg_idx_t  issue_rd_i,
    output reg_mask_t      pending_o,
    output logic           busy_o,
    output logic           wb_o
);
    localparam logic [3:0] LAT_INIT = 4'(MULDIV_LAT);

    reg_mask_t  pending_q, pending_d;
    logic [3:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d     = cnt_q;
        pending_d = pending_q;
        if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
        end
        // At most one op is in flight, so writeback clears the whole mask;
        // a reissue on the same edge is applied afterwards and therefore wins.
        if (wb_o) begin
            pending_d = '0;
        end
        if (issue_i) begin
            cnt_d                 = LAT_INIT;
            pending_d[issue_rd_i] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            pending_q <= '0;
            cnt_q     <= 4'd0;
        end else begin
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
        end
    end

    assign pending_o = pending_q;
    assign busy_o    = (cnt_q != 4'd0);
    assign wb_o      = (cnt_q == 4'd1);
endmodule

`default_nettype wire

// File: rtl/hazard_stall_unit.sv
//------------------------------------------------------------------------------
// Module   : hazard_stall_unit
// Brief    : Decode-stage load-use / mul-div hazard stall and branch flush control.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module hazard_stall_unit
    import hazard_stall_unit_pkg::*;
#(
    parameter int MULDIV_LAT = MULDIV_LAT_DEF,
    parameter int CNT_W      = 16
) (
    input  wire logic          clk,
    input  wire logic          arst_n,
    hazard_stall_unit_if.slave bus
);
    reg_mask_t        w_pending;
    logic             w_busy;
    logic             w_wb;
    logic             w_lu;
    logic             w_sb;
    logic             w_st;
    logic             w_waw;
    logic             w_stall;
    logic             w_issue;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;

    mul_div_scoreboard #(
        .MULDIV_LAT (MULDIV_LAT)
    ) u_scoreboard (
        .clk        (clk),
        .arst_n     (arst_n),
        .issue_i    (w_issue),
        .issue_rd_i (bus.id_reg_rd),
        .pending_o  (w_pending),
        .busy_o     (w_busy),
        .wb_o       (w_wb)
    );

    // $0 is never a real load destination, so it cannot create a dependency.
    assign w_lu = bus.exe_mem_read && (bus.exe_reg_rd != REG_ZERO) &&
                  ((bus.id_uses_rs && (bus.id_reg_rs == bus.exe_reg_rd)) ||
                   (bus.id_uses_rt && (bus.id_reg_rt == bus.exe_reg_rd)));
    assign w_sb = (bus.id_uses_rs && w_pending[bus.id_reg_rs]) ||
                  (bus.id_uses_rt && w_pending[bus.id_reg_rt]);
    assign w_st  = bus.id_is_muldiv && w_busy && !w_wb;
    assign w_waw = bus.id_reg_write && w_pending[bus.id_reg_rd];

    assign w_stall = bus.id_valid && !bus.branch_taken &&
                     (w_lu || w_sb || w_st || w_waw);
    assign w_issue = bus.id_valid && !w_stall && !bus.branch_taken &&
                     bus.id_is_muldiv && bus.id_reg_write &&
                     (bus.id_reg_rd != REG_ZERO);

    always_comb begin
        stall_count_d = stall_count_q;
        if (w_stall && (stall_count_q != {CNT_W{1'b1}})) begin
            stall_count_d = stall_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            stall_count_q <= '0;
        end else begin
            stall_count_q <= stall_count_d;
        end
    end

    assign bus.stall_if    = w_stall;
    assign bus.stall_id    = w_stall;
    assign bus.bubble_ex   = w_stall || bus.branch_taken;
    assign bus.flush_id    = bus.branch_taken;
    assign bus.muldiv_busy = w_busy;
    assign bus.muldiv_wb   = w_wb;
    assign bus.stall_count = stall_count_q;
endmodule

`default_nettype wire

// File: tb/tb_hazard_stall_unit.sv
//------------------------------------------------------------------------------
// Module   : tb_hazard_stall_unit
// Brief    : Directed self-checking bench for hazard_stall_unit (MULDIV_LAT=4).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_hazard_stall_unit;
    localparam int CNT_W = 4;

    logic clk;
    logic arst_n;
    int   n_checks;
    int   n_err;

    hazard_stall_unit_if #(.CNT_W(CNT_W)) bus ();

    hazard_stall_unit #(
        .MULDIV_LAT (4),
        .CNT_W      (CNT_W)
    ) dut (
        .clk    (clk),
        .arst_n (arst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // {stall_if, stall_id, bubble_ex, flush_id}
    task automatic chk_ctrl(input string tag, input logic [3:0] exp);
        chk(tag, {28'd0, bus.stall_if, bus.stall_id, bus.bubble_ex, bus.flush_id}, {28'd0, exp});
    endtask

    task automatic chk_md(input string tag, input logic busy, input logic wb);
        chk(tag, {30'd0, bus.muldiv_busy, bus.muldiv_wb}, {30'd0, busy, wb});
    endtask

    task automatic idle();
        bus.id_valid     = 1'b0;
        bus.id_reg_rs    = 5'd0;
        bus.id_reg_rt    = 5'd0;
        bus.id_uses_rs   = 1'b0;
        bus.id_uses_rt   = 1'b0;
        bus.id_reg_rd    = 5'd0;
        bus.id_reg_write = 1'b0;
        bus.id_is_muldiv = 1'b0;
        bus.exe_mem_read = 1'b0;
        bus.exe_reg_rd   = 5'd0;
        bus.branch_taken = 1'b0;
    endtask

    task automatic set_id(input logic [4:0] rs, input logic urs, input logic [4:0] rt,
                          input logic urt, input logic [4:0] rd, input logic rw,
                          input logic md);
        bus.id_valid     = 1'b1;
        bus.id_reg_rs    = rs;
        bus.id_uses_rs   = urs;
        bus.id_reg_rt    = rt;
        bus.id_uses_rt   = urt;
        bus.id_reg_rd    = rd;
        bus.id_reg_write = rw;
        bus.id_is_muldiv = md;
    endtask

    task automatic step();
        @(negedge clk);
        idle();
    endtask

    initial begin
        n_checks = 0;
        n_err    = 0;
        arst_n   = 1'b0;
        idle();
        #1;
        chk_ctrl("reset_ctrl", 4'b0000);
        chk_md("reset_md", 1'b0, 1'b0);
        chk("reset_cnt", 32'(bus.stall_count), 32'd0);
        @(negedge clk);
        arst_n = 1'b1;

        // load-use on rs
        step(); bus.exe_mem_read = 1'b1; bus.exe_reg_rd = 5'd5;
        set_id(5'd5, 1'b1, 5'd6, 1'b1, 5'd7, 1'b1, 1'b0); #1;
        chk_ctrl("lu_rs_stall", 4'b1110);
        step(); set_id(5'd5, 1'b1, 5'd6, 1'b1, 5'd7, 1'b1, 1'b0); #1;
        chk_ctrl("lu_released", 4'b0000);
        chk("lu_cnt", 32'(bus.stall_count), 32'd1);

        // $0 immunity
        step(); bus.exe_mem_read = 1'b1; bus.exe_reg_rd = 5'd0;
        set_id(5'd0, 1'b1, 5'd0, 1'b1, 5'd3, 1'b1, 1'b0); #1;
        chk_ctrl("lu_zero", 4'b0000);

        // load-use on rt only
        step(); bus.exe_mem_read = 1'b1; bus.exe_reg_rd = 5'd7;
        set_id(5'd7, 1'b0, 5'd7, 1'b1, 5'd3, 1'b1, 1'b0); #1;
        chk_ctrl("lu_rt_stall", 4'b1110);

        // matching registers but not actually read
        step(); bus.exe_mem_read = 1'b1; bus.exe_reg_rd = 5'd7;
        set_id(5'd7, 1'b0, 5'd7, 1'b0, 5'd3, 1'b1, 1'b0); #1;
        chk_ctrl("lu_unused", 4'b0000);
        chk("lu_cnt2", 32'(bus.stall_count), 32'd2);

        // mul $8, then dependent add stalls 4 cycles
        step(); set_id(5'd1, 1'b1, 5'd2, 1'b1, 5'd8, 1'b1, 1'b1); #1;
        chk_ctrl("mul_issue", 4'b0000);
        chk_md("mul_pre_md", 1'b0, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            step(); set_id(5'd8, 1'b1, 5'd3, 1'b1, 5'd9, 1'b1, 1'b0); #1;
            chk_ctrl($sformatf("dep_stall_%0d", i), 4'b1110);
            chk_md($sformatf("dep_md_%0d", i), 1'b1, (i == 4));
        end
        step(); set_id(5'd8, 1'b1, 5'd3, 1'b1, 5'd9, 1'b1, 1'b0); #1;
        chk_ctrl("dep_release", 4'b0000);
        chk_md("dep_md_done", 1'b0, 1'b0);
        chk("dep_cnt", 32'(bus.stall_count), 32'd6);

        // back-to-back mul/div: second issues on the writeback cycle
        step(); set_id(5'd1, 1'b1, 5'd2, 1'b1, 5'd10, 1'b1, 1'b1); #1;
        chk_ctrl("b2b_first", 4'b0000);
        for (int i = 1; i <= 4; i++) begin
            step(); set_id(5'd3, 1'b1, 5'd4, 1'b1, 5'd11, 1'b1, 1'b1); #1;
            chk_ctrl($sformatf("b2b_ctrl_%0d", i), (i == 4) ? 4'b0000 : 4'b1110);
            chk_md($sformatf("b2b_md_%0d", i), 1'b1, (i == 4));
        end

        // branch beats a scoreboard stall on $11
        step(); bus.branch_taken = 1'b1;
        set_id(5'd11, 1'b1, 5'd2, 1'b1, 5'd12, 1'b1, 1'b0); #1;
        chk_ctrl("br_flush", 4'b0011);
        chk_md("b2b_reload_1", 1'b1, 1'b0);
        step(); set_id(5'd11, 1'b1, 5'd2, 1'b1, 5'd12, 1'b1, 1'b0); #1;
        chk_ctrl("br_pending_kept", 4'b1110);
        chk_md("b2b_reload_2", 1'b1, 1'b0);
        step(); set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd11, 1'b1, 1'b0); #1;
        chk_ctrl("waw_stall", 4'b1110);
        step(); #1;
        chk_md("b2b_wb", 1'b1, 1'b1);
        step(); #1;
        chk_md("b2b_done", 1'b0, 1'b0);
        chk("b2b_cnt", 32'(bus.stall_count), 32'd11);

        // reset mid-operation with cnt == 2
        step(); set_id(5'd1, 1'b1, 5'd2, 1'b1, 5'd13, 1'b1, 1'b1); #1;
        step(); #1;
        step(); #1;
        step(); #1;
        chk_md("rst_pre_md", 1'b1, 1'b0);
        arst_n = 1'b0; #1;
        chk_ctrl("rst_mid_ctrl", 4'b0000);
        chk_md("rst_mid_md", 1'b0, 1'b0);
        chk("rst_mid_cnt", 32'(bus.stall_count), 32'd0);
        #2 arst_n = 1'b1;
        step(); set_id(5'd13, 1'b1, 5'd0, 1'b0, 5'd14, 1'b1, 1'b0); #1;
        chk_ctrl("rst_pending_clr", 4'b0000);
        for (int i = 0; i < 4; i++) begin
            step(); #1;
            chk_md($sformatf("rst_no_wb_%0d", i), 1'b0, 1'b0);
        end

        // stall counter saturation
        for (int i = 0; i < 20; i++) begin
            step(); bus.exe_mem_read = 1'b1; bus.exe_reg_rd = 5'd5;
            set_id(5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0); #1;
            if (i == 10) chk("sat_mid", 32'(bus.stall_count), 32'd10);
        end
        step(); #1;
        chk("sat_full", 32'(bus.stall_count), 32'd15);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/hazard_stall_unit.md
# hazard_stall_unit

Decode-stage hazard controller for the 5-stage MIPS pipeline; it handles the hazards the EX-stage forwarding unit cannot bypass. It detects load-use dependencies and dependencies on a multi-cycle mul/div result, holds PC and IF/ID, and injects bubbles into ID/EX. It also squashes wrong-path work on a taken branch. A per-register scoreboard tracks the single in-flight mul/div destination until its writeback.

## Interface
Parameters:
- MULDIV_LAT, 4: cycles from mul/div issue (ID→EX edge) to its register-file write; legal 2..15
- CNT_W, 16: width of the stall performance counter

Ports:
- clk  in  1  pipeline clock, rising edge
- arst_n  in  1  asynchronous, active-low reset
- id_valid  in  1  ID holds a real instruction
- id_reg_rs  in  5  ID source register rs
- id_reg_rt  in  5  ID source register rt
- id_uses_rs  in  1  ID instruction reads rs
- id_uses_rt  in  1  ID instruction reads rt
- id_reg_rd  in  5  ID destination register
- id_reg_write  in  1  ID instruction writes a register
- id_is_muldiv  in  1  ID instruction is a multi-cycle mul/div
- exe_mem_read  in  1  EX instruction is a load
- exe_reg_rd  in  5  EX destination register
- branch_taken  in  1  EX resolved a taken branch/jump this cycle
- stall_if  out  1  hold PC
- stall_id  out  1  hold IF/ID register
- bubble_ex  out  1  load NOP into ID/EX
- flush_id  out  1  clear IF/ID to NOP
- muldiv_busy  out  1  a mul/div is in flight
- muldiv_wb  out  1  mul/div writeback occurs at the coming edge
- stall_count  out  CNT_W  saturating count of stall cycles

## Operation
- State: pending[31:0] scoreboard, cnt[3:0] mul/div countdown, stall_count.
- Load-use: lu = exe_mem_read & exe_reg_rd!=0 & ((id_uses_rs & id_reg_rs==exe_reg_rd) | (id_uses_rt & id_reg_rt==exe_reg_rd)).
- Scoreboard: sb = (id_uses_rs & pending[id_reg_rs]) | (id_uses_rt & pending[id_reg_rt]). pending[0] is never set.
- Structural: st = id_is_muldiv & muldiv_busy & ~muldiv_wb. A new mul/div may issue in the cycle the old one writes back.
- WAW: waw = id_reg_write & pending[id_reg_rd]. A write to a pending register stalls.
- stall = id_valid & ~branch_taken & (lu | sb | st | waw).
- Priority: branch_taken beats stall. Wrong-path ID is discarded and never issues.
- Outputs: stall_if = stall_id = stall. bubble_ex = stall | branch_taken. flush_id = branch_taken.
- Issue: issue = id_valid & ~stall & ~branch_taken & id_is_muldiv & id_reg_write & id_reg_rd!=0. On issue: pending[id_reg_rd]<=1, cnt<=MULDIV_LAT.
- Countdown: cnt decrements when nonzero. muldiv_busy = cnt!=0. muldiv_wb = cnt==1.
- Writeback: at the edge where muldiv_wb=1, cnt→0 (or reload on simultaneous issue) and the old pending bit clears. If the same rd is reissued at that edge, set wins.
- A mul/div already past ID is older than any branch in EX. branch_taken does not cancel it.
- stall_count increments each cycle stall=1 and saturates at all-ones.

## Timing
- Reset (arst_n low, async): pending=0, cnt=0, stall_count=0. All outputs 0.
- Reset mid-mul/div abandons the operation; no muldiv_wb is produced.
- stall, bubble_ex and flush_id are combinational from inputs and registered state, settled within the same cycle. No added latency.
- Load-use: exactly 1 stall cycle. The next cycle the load is in MEM and is forwarded.
- Mul/div dependent issued right behind: ID stalls while pending is set, including the muldiv_wb cycle, so MULDIV_LAT cycles total. It is released the cycle after muldiv_wb, when the register file already holds the result.
- muldiv_busy is high for exactly MULDIV_LAT cycles after the issue edge.

## Structure
- Shared pipeline package: register index width (5), REG_ZERO constant, MULDIV_LAT default.
- Sub-module mul_div_scoreboard holds pending[], cnt, and the issue/writeback logic. The top level holds the hazard equations and the perf counter.

## Test plan
- Load-use: lw $5 in EX, add rs=$5 in ID → stall_if=stall_id=bubble_ex=1 for 1 cycle, stall_count=1.
- $0 immunity: lw $0 in EX, ID reads $0 → no stall.
- mul to $8 (MULDIV_LAT=4), then add reading $8 → muldiv_wb high on the 4th cycle after issue, stall for 4 cycles, add issues in cycle 5.
- Back-to-back mul/div: second mul/div stalls while busy and issues in the muldiv_wb cycle. busy stays continuously high, cnt reloads to 4.
- branch_taken while ID would stall on $8 → flush_id=1, bubble_ex=1, stall=0, no issue, pending unchanged.
- arst_n pulsed low with cnt=2 → all outputs and stall_count 0 immediately, no muldiv_wb afterwards.
